// File: rtl/ttc_param18.sv
// Purpose : NUM_CH-channel APB timer/counter with prescaler, up/down, interval/overflow,
//           one-shot, match compare and maskable per-channel interrupts.
// Latency : zero-wait-state APB; writes commit on the access edge, prdata18 is combinational.
// Backpr. : none - the slave is always ready, so psel18/penable18 are never stalled.
// Ports   : pclk18/p_reset18 (async, active-high) clock and reset; psel18, penable18, pwrite18,
//           paddr18 ([7:5] channel, [4:0] offset), pwdata18, prdata18 form the APB slave;
//           interrupt18[c] = |(ISR_c & IER_c); scan_en18/scan_in18 are unused, scan_out18 is 0.
module ttc_param18 #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 16
) (
    input  logic              pclk18,
    input  logic              p_reset18,
    input  logic              psel18,
    input  logic              penable18,
    input  logic              pwrite18,
    input  logic [7:0]        paddr18,
    input  logic [31:0]       pwdata18,
    input  logic              scan_en18,
    input  logic              scan_in18,
    output logic [31:0]       prdata18,
    output logic [NUM_CH-1:0] interrupt18,
    output logic              scan_out18
);
    localparam logic [4:0]       OFF_CTRL  = 5'h00;
    localparam logic [4:0]       OFF_INTV  = 5'h04;
    localparam logic [4:0]       OFF_MATCH = 5'h08;
    localparam logic [4:0]       OFF_COUNT = 5'h0C;
    localparam logic [4:0]       OFF_ISR   = 5'h10;
    localparam logic [4:0]       OFF_IER   = 5'h14;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic        wr_en;
    logic [2:0]  ch_sel;
    logic [4:0]  off;
    logic [31:0] rd_ch [NUM_CH];
    logic        unused_ok;

    assign wr_en      = psel18 & penable18 & pwrite18;
    assign ch_sel     = paddr18[7:5];
    assign off        = paddr18[4:0];
    assign scan_out18 = 1'b0;
    // Scan pins and the upper write-data bits have no functional use.
    assign unused_ok  = &{1'b0, scan_en18, scan_in18, pwdata18[31:10]};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             en, mode, dec, oneshot, ps_en;
        logic [3:0]       ps;
        logic [15:0]      presc;
        logic [15:0]      ps_term;
        logic [CNT_W-1:0] count, interval, match;
        logic [CNT_W-1:0] up_top, cnt_next;
        logic [1:0]       isr, ier, isr_set, isr_clr;
        logic             hit, ctrl_wr, intv_wr, match_wr, isr_wr, ier_wr;
        logic             rst_cnt, tick, tick_ev, wrap;
        logic [31:0]      rd;

        assign hit      = wr_en && (ch_sel == 3'(g));
        assign ctrl_wr  = hit && (off == OFF_CTRL);
        assign intv_wr  = hit && (off == OFF_INTV);
        assign match_wr = hit && (off == OFF_MATCH);
        assign isr_wr   = hit && (off == OFF_ISR);
        assign ier_wr   = hit && (off == OFF_IER);
        assign rst_cnt  = ctrl_wr && pwdata18[4];

        // Prescaler terminal value 2^(PS+1)-1; computed one bit wider so PS=15 fits.
        assign ps_term  = 16'((17'd1 << ({1'b0, ps} + 5'd1)) - 17'd1);
        assign tick     = en && (!ps_en || (presc == ps_term));
        // A counter reset in the same cycle suppresses the tick and its events.
        assign tick_ev  = tick && !rst_cnt;

        // Up-count compare point doubles as the down-count reload value.
        assign up_top   = mode ? interval : CNT_MAX;
        assign wrap     = dec ? (count == '0) : (count == up_top);

        always_comb begin
            cnt_next = dec ? (count - CNT_W'(1)) : (count + CNT_W'(1));
            if (wrap) begin
                cnt_next = dec ? up_top : '0;
            end
        end

        assign isr_set = {tick_ev && (cnt_next == match), tick_ev && wrap};
        assign isr_clr = isr_wr ? pwdata18[1:0] : 2'b00;

        always_ff @(posedge pclk18 or posedge p_reset18) begin
            if (p_reset18) begin
                en       <= 1'b0;
                mode     <= 1'b0;
                dec      <= 1'b0;
                oneshot  <= 1'b0;
                ps       <= '0;
                ps_en    <= 1'b0;
                presc    <= '0;
                count    <= '0;
                interval <= '0;
                match    <= '0;
                isr      <= '0;
                ier      <= '0;
            end else begin
                // A software CTRL write overrides the one-shot hardware clear of EN.
                if (ctrl_wr) begin
                    en      <= pwdata18[0];
                    mode    <= pwdata18[1];
                    dec     <= pwdata18[2];
                    oneshot <= pwdata18[3];
                    ps      <= pwdata18[8:5];
                    ps_en   <= pwdata18[9];
                end else if (tick_ev && wrap && oneshot) begin
                    en <= 1'b0;
                end
                if (intv_wr) begin
                    interval <= pwdata18[CNT_W-1:0];
                end
                if (match_wr) begin
                    match <= pwdata18[CNT_W-1:0];
                end
                if (ier_wr) begin
                    ier <= pwdata18[1:0];
                end
                // Hardware set beats a same-cycle write-1-to-clear.
                isr <= (isr & ~isr_clr) | isr_set;
                if (rst_cnt) begin
                    count <= pwdata18[2] ? interval : '0;
                    presc <= '0;
                end else begin
                    if (tick) begin
                        count <= cnt_next;
                    end
                    if (en && ps_en) begin
                        presc <= (presc == ps_term) ? '0 : (presc + 16'd1);
                    end
                end
            end
        end

        always_comb begin
            rd = '0;
            case (off)
                OFF_CTRL:  rd = 32'({ps_en, ps, 1'b0, oneshot, dec, mode, en});
                OFF_INTV:  rd = 32'(interval);
                OFF_MATCH: rd = 32'(match);
                OFF_COUNT: rd = 32'(count);
                OFF_ISR:   rd = {30'd0, isr};
                OFF_IER:   rd = {30'd0, ier};
                default:   rd = '0;
            endcase
        end

        assign rd_ch[g]       = rd;
        assign interrupt18[g] = |(isr & ier);
    end

    // Channels at or above NUM_CH match no loop index and read as zero.
    always_comb begin
        prdata18 = '0;
        if (psel18 && !pwrite18) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_sel == 3'(c)) begin
                    prdata18 = rd_ch[c];
                end
            end
        end
    end

endmodule
